// File: rtl/ssp_sync_to_pclk.sv
// ssp_sync_to_pclk
// PCLK-domain return path for the SSP. It brings SSPCLK status levels and
// toggle-encoded events into PCLK and turns each toggle into a one-cycle pulse.
// It also runs the four-phase req/ack handshakes that carry SSPCR0 and SSPCPSR
// updates across to SSPCLK, with busy flags so register writes are not lost.
// SYNC_STAGES is the depth of every SSPCLK->PCLK synchroniser; legal 2..3.

module ssp_sync_to_pclk #(
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic TxRdToggle,
  input  logic RxWrToggle,
  input  logic RORToggle,
  input  logic RTIntr,
  input  logic BSY,
  input  logic CR0Write,
  input  logic CPSRWrite,
  input  logic CR0Ack,
  input  logic CPSRAck,
  output logic TxRdPulse,
  output logic RxWrPulse,
  output logic RORPulse,
  output logic RTIntrSync,
  output logic BSYSync,
  output logic CR0Update,
  output logic CPSRUpdate,
  output logic CR0Busy,
  output logic CPSRBusy
);

  // Bit positions of the crossings inside the bundled synchroniser.
  localparam int X_TXRD   = 0;
  localparam int X_RXWR   = 1;
  localparam int X_ROR    = 2;
  localparam int X_RTINTR = 3;
  localparam int X_BSY    = 4;
  localparam int X_CR0ACK = 5;
  localparam int X_CPSACK = 6;
  localparam int NUM_X    = 7;

  // Handshake channel indices.
  localparam int CH_CR0  = 0;
  localparam int CH_CPSR = 1;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_DROP = 2'd2
  } hs_state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser chains for every SSPCLK-domain input
  // ---------------------------------------------------------------------------
  logic [NUM_X-1:0]                  x_in;
  logic [NUM_X-1:0]                  x_sync;
  logic [SYNC_STAGES-1:0][NUM_X-1:0] chain_q, chain_d;

  assign x_in = {CPSRAck, CR0Ack, BSY, RTIntr, RORToggle, RxWrToggle, TxRdToggle};
  assign x_sync = chain_q[SYNC_STAGES-1];

  // Shift every crossing one stage further down its chain.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path
    // can leave it unassigned and infer a latch.
    chain_d    = chain_q;
    chain_d[0] = x_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Synchroniser flops, cleared by reset so no stale SSPCLK state survives.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge inputs regardless of the order of the statements.
    if (PRESET) begin
      // NOTE: the synchroniser flops are reset. The SSPCLK side is reset by
      // the same system reset, so the chains restart from a known 0 that
      // matches the far side.
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Toggle-to-pulse conversion
  // The synchronised toggle is retimed once (hold) and a second flop keeps the
  // previous value (prev). Their XOR, registered, gives one pulse per edge.
  // ---------------------------------------------------------------------------
  logic [2:0] tog_hold_q, tog_hold_d;
  logic [2:0] tog_prev_q, tog_prev_d;
  logic [2:0] pulse_q,    pulse_d;

  // Edge detect on the retimed toggles.
  always_comb begin
    tog_hold_d = x_sync[X_ROR:X_TXRD];
    tog_prev_d = tog_hold_q;
    pulse_d    = tog_hold_q ^ tog_prev_q;
  end

  // Toggle history and pulse output flops.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tog_hold_q <= '0;
      tog_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      tog_hold_q <= tog_hold_d;
      tog_prev_q <= tog_prev_d;
      pulse_q    <= pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Update handshakes (channel 0 = SSPCR0, channel 1 = SSPCPSR)
  // A write while a handshake is in flight only sets the pending flag. The
  // SSPCLK side samples the live register value, so merged writes lose nothing.
  // ---------------------------------------------------------------------------
  hs_state_t  state_q [2];
  logic [1:0] pending_q;
  logic [1:0] update_q;
  logic [1:0] busy_q;
  logic [1:0] hs_write;
  logic [1:0] hs_ack;

  assign hs_write = {CPSRWrite, CR0Write};
  assign hs_ack   = {x_sync[X_CPSACK], x_sync[X_CR0ACK]};

  // Both four-phase handshake FSMs, with registered Update and Busy outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]   <= HS_IDLE;
        pending_q[c] <= 1'b0;
        update_q[c]  <= 1'b0;
        busy_q[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (state_q[c])
          HS_IDLE: begin
            if (hs_write[c]) begin
              state_q[c]  <= HS_REQ;
              update_q[c] <= 1'b1;
              busy_q[c]   <= 1'b1;
            end
          end
          HS_REQ: begin
            if (hs_write[c]) begin
              pending_q[c] <= 1'b1;
            end
            if (hs_ack[c]) begin
              state_q[c]  <= HS_DROP;
              update_q[c] <= 1'b0;
            end
          end
          HS_DROP: begin
            if (!hs_ack[c]) begin
              if (pending_q[c] || hs_write[c]) begin
                // Restart at once; a write on this edge merges into it.
                state_q[c]   <= HS_REQ;
                update_q[c]  <= 1'b1;
                pending_q[c] <= 1'b0;
              end else begin
                state_q[c] <= HS_IDLE;
                busy_q[c]  <= 1'b0;
              end
            end else if (hs_write[c]) begin
              pending_q[c] <= 1'b1;
            end
          end
          default: begin
            state_q[c]   <= HS_IDLE;
            pending_q[c] <= 1'b0;
            update_q[c]  <= 1'b0;
            busy_q[c]    <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign TxRdPulse  = pulse_q[X_TXRD];
  assign RxWrPulse  = pulse_q[X_RXWR];
  assign RORPulse   = pulse_q[X_ROR];
  assign RTIntrSync = x_sync[X_RTINTR];
  assign BSYSync    = x_sync[X_BSY];
  assign CR0Update  = update_q[CH_CR0];
  assign CPSRUpdate = update_q[CH_CPSR];
  assign CR0Busy    = busy_q[CH_CR0];
  assign CPSRBusy   = busy_q[CH_CPSR];

endmodule

// File: tb/tb_ssp_sync_to_pclk.sv
// tb_ssp_sync_to_pclk
// Directed bench for ssp_sync_to_pclk. Expected pulses and handshake output
// transitions are queued when stimulus is applied. Monitors on the falling
// clock edge pop those entries and compare them with the DUT outputs.

module tb_ssp_sync_to_pclk;

  localparam int S       = 2;
  localparam int D_CR0   = 4;          // ack model delay, SSPCR0 channel
  localparam int D_CPSR  = 6;          // ack model delay, SSPCPSR channel
  localparam int P_CR0   = S + D_CR0;  // length of one REQ or DROP phase
  localparam int P_CPSR  = S + D_CPSR;

  typedef struct {
    int   cyc;
    logic upd;
    logic bsy;
  } hs_ev_t;

  logic pclk = 1'b0;
  logic preset;
  logic [2:0] tog;
  logic rtintr, bsy;
  logic cr0_write, cpsr_write;
  logic force_ack;
  logic cr0_ack, cpsr_ack;
  logic [3:0] cr0_dly;
  logic [5:0] cpsr_dly;

  logic tx_pulse, rx_pulse, ror_pulse;
  logic rtintr_sync, bsy_sync;
  logic cr0_update, cpsr_update, cr0_busy, cpsr_busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  int     q_pulse [3][$];
  hs_ev_t hs_q    [2][$];
  logic   exp_upd [2];
  logic   exp_bsy [2];

  ssp_sync_to_pclk #(.SYNC_STAGES(S)) dut (
    .PCLK      (pclk),
    .PRESET    (preset),
    .TxRdToggle(tog[0]),
    .RxWrToggle(tog[1]),
    .RORToggle (tog[2]),
    .RTIntr    (rtintr),
    .BSY       (bsy),
    .CR0Write  (cr0_write),
    .CPSRWrite (cpsr_write),
    .CR0Ack    (cr0_ack),
    .CPSRAck   (cpsr_ack),
    .TxRdPulse (tx_pulse),
    .RxWrPulse (rx_pulse),
    .RORPulse  (ror_pulse),
    .RTIntrSync(rtintr_sync),
    .BSYSync   (bsy_sync),
    .CR0Update (cr0_update),
    .CPSRUpdate(cpsr_update),
    .CR0Busy   (cr0_busy),
    .CPSRBusy  (cpsr_busy)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // SSPCLK-side stand-in: each ack echoes its Update a fixed delay later and
  // is cleared by the shared system reset.
  initial begin
    cr0_dly  = '0;
    cpsr_dly = '0;
    forever begin
      @(posedge pclk);
      #2;
      if (preset) begin
        cr0_dly  = '0;
        cpsr_dly = '0;
      end else begin
        cr0_dly  = {cr0_dly[2:0], cr0_update};
        cpsr_dly = {cpsr_dly[4:0], cpsr_update};
      end
    end
  end

  assign cr0_ack  = force_ack | cr0_dly[D_CR0-1];
  assign cpsr_ack = force_ack | cpsr_dly[D_CPSR-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // A toggle driven now is sampled on the next edge; the pulse follows S+1 later.
  task automatic flip(input int i);
    tog[i] = ~tog[i];
    q_pulse[i].push_back(cyc + S + 2);
  endtask

  task automatic push_ev(input int c, input int at, input logic upd, input logic bsy_v);
    hs_ev_t ev;
    ev.cyc = at;
    ev.upd = upd;
    ev.bsy = bsy_v;
    hs_q[c].push_back(ev);
  endtask

  // Expected outputs for one handshake (two if restarted) from a write driven now.
  task automatic expect_hs(input int c, input int p, input bit second);
    int u;
    u = cyc + 1;
    push_ev(c, u, 1'b1, 1'b1);
    push_ev(c, u + p, 1'b0, 1'b1);
    if (second) begin
      push_ev(c, u + 2*p, 1'b1, 1'b1);
      push_ev(c, u + 3*p, 1'b0, 1'b1);
      push_ev(c, u + 4*p, 1'b0, 1'b0);
    end else begin
      push_ev(c, u + 2*p, 1'b0, 1'b0);
    end
  endtask

  // A reset driven now cancels future transitions and clears both channels.
  task automatic expect_reset();
    for (int c = 0; c < 2; c++) begin
      while (hs_q[c].size() > 0 && hs_q[c][hs_q[c].size()-1].cyc >= cyc + 1)
        void'(hs_q[c].pop_back());
      push_ev(c, cyc + 1, 1'b0, 1'b0);
    end
  endtask

  // Pulse scoreboard: compare whenever a pulse is seen or one is due.
  always @(negedge pclk) begin
    logic [2:0] obs;
    logic       due;
    obs = {ror_pulse, rx_pulse, tx_pulse};
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        due = (q_pulse[i].size() > 0) && (q_pulse[i][0] == cyc);
        if (obs[i] || due) begin
          check($sformatf("pulse%0d", i), {31'd0, obs[i]}, {31'd0, due});
          if (due) void'(q_pulse[i].pop_front());
        end
      end
    end
  end

  // Handshake scoreboard: apply due transitions, then compare every cycle.
  always @(negedge pclk) begin
    logic [1:0] upd_obs;
    logic [1:0] bsy_obs;
    upd_obs = {cpsr_update, cr0_update};
    bsy_obs = {cpsr_busy, cr0_busy};
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        while (hs_q[c].size() > 0 && hs_q[c][0].cyc <= cyc) begin
          exp_upd[c] = hs_q[c][0].upd;
          exp_bsy[c] = hs_q[c][0].bsy;
          void'(hs_q[c].pop_front());
        end
        check($sformatf("update%0d", c), {31'd0, upd_obs[c]}, {31'd0, exp_upd[c]});
        check($sformatf("busy%0d", c),   {31'd0, bsy_obs[c]}, {31'd0, exp_bsy[c]});
      end
    end
  end

  initial begin
    int e;
    exp_upd[0] = 1'b0; exp_upd[1] = 1'b0;
    exp_bsy[0] = 1'b0; exp_bsy[1] = 1'b0;

    // Reset held with every input high.
    preset     = 1'b1;
    tog        = 3'b111;
    rtintr     = 1'b1;
    bsy        = 1'b1;
    cr0_write  = 1'b1;
    cpsr_write = 1'b1;
    force_ack  = 1'b1;
    tick(1);
    mon_en = 1'b1;
    tick(2);
    check("rst_txpulse", {31'd0, tx_pulse},    32'd0);
    check("rst_rxpulse", {31'd0, rx_pulse},    32'd0);
    check("rst_rorpulse", {31'd0, ror_pulse},  32'd0);
    check("rst_rtintr",  {31'd0, rtintr_sync}, 32'd0);
    check("rst_bsy",     {31'd0, bsy_sync},    32'd0);

    // Release; the SSPCLK side leaves reset with its toggles and acks at 0.
    preset     = 1'b0;
    tog        = 3'b000;
    cr0_write  = 1'b0;
    cpsr_write = 1'b0;
    force_ack  = 1'b0;
    tick(S - 1);
    check("rel_rtintr_early", {31'd0, rtintr_sync}, 32'd0);
    check("rel_bsy_early",    {31'd0, bsy_sync},    32'd0);
    tick(1);
    check("rel_rtintr", {31'd0, rtintr_sync}, 32'd1);
    check("rel_bsy",    {31'd0, bsy_sync},    32'd1);
    tick(4);

    // Level latency on the falling side.
    rtintr = 1'b0;
    bsy    = 1'b0;
    tick(S - 1);
    check("lvl_rtintr_hold", {31'd0, rtintr_sync}, 32'd1);
    check("lvl_bsy_hold",    {31'd0, bsy_sync},    32'd1);
    tick(1);
    check("lvl_rtintr_fall", {31'd0, rtintr_sync}, 32'd0);
    check("lvl_bsy_fall",    {31'd0, bsy_sync},    32'd0);
    tick(2);

    // Two flips per toggle input, eight cycles apart.
    for (int i = 0; i < 3; i++) begin
      flip(i);
      tick(8);
      flip(i);
      tick(8);
    end

    // Single CR0 handshake.
    cr0_write = 1'b1;
    expect_hs(0, P_CR0, 1'b0);
    tick(1);
    cr0_write = 1'b0;
    tick(2*P_CR0 + 4);

    // Three writes during REQ/DROP merge into exactly one extra REQ phase.
    e = cyc;
    cr0_write = 1'b1;
    expect_hs(0, P_CR0, 1'b1);
    tick(1);
    cr0_write = 1'b0;
    tick(1);
    cr0_write = 1'b1;
    tick(1);
    cr0_write = 1'b0;
    tick(1);
    cr0_write = 1'b1;
    tick(1);
    cr0_write = 1'b0;
    tick(e + P_CR0 + 2 - cyc);
    cr0_write = 1'b1;
    tick(1);
    cr0_write = 1'b0;
    tick(4*P_CR0 + 4);

    // Both channels written together, each with its own ack delay.
    cr0_write  = 1'b1;
    cpsr_write = 1'b1;
    expect_hs(0, P_CR0, 1'b0);
    expect_hs(1, P_CPSR, 1'b0);
    tick(1);
    cr0_write  = 1'b0;
    cpsr_write = 1'b0;
    tick(2*P_CPSR + 4);

    // Reset during REQ, then a fresh write must still complete.
    cpsr_write = 1'b1;
    expect_hs(1, P_CPSR, 1'b0);
    tick(1);
    cpsr_write = 1'b0;
    tick(2);
    preset = 1'b1;
    expect_reset();
    tick(1);
    preset = 1'b0;
    tick(3);
    cpsr_write = 1'b1;
    expect_hs(1, P_CPSR, 1'b0);
    tick(1);
    cpsr_write = 1'b0;
    tick(2*P_CPSR + 4);

    for (int i = 0; i < 3; i++)
      check($sformatf("pulse%0d_left", i), q_pulse[i].size(), 32'd0);
    for (int c = 0; c < 2; c++)
      check($sformatf("hs%0d_left", c), hs_q[c].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
